// File: rtl/flag_fifo.sv
// rtl/flag_fifo.sv - DEPTH-entry flag queue with occupancy, full, sticky overrun and selectable full-policy
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   set_flag     push strobe, din captured on the rising edge
//   din          data to push
//   clr_flag     pop strobe, discards the oldest entry
//   clr_overrun  clears the sticky overrun flag
//   flag         queue non-empty
//   dout         oldest entry, valid while flag = 1
//   full         count == DEPTH
//   count        number of stored entries, 0..DEPTH
//   overrun      sticky: push while full without a simultaneous pop
module flag_fifo #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int OVERWRITE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_flag,
   input  logic [DATA_W-1:0] din,
   input  logic              clr_flag,
   input  logic              clr_overrun,
   output logic              flag,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   logic is_empty;
   logic is_full;
   logic overflow;
   logic wr_en;
   logic rd_adv;

   always_comb begin
      is_empty = (count == '0);
      is_full  = (count == DEPTH_C);
      // A push into a full queue with no pop in the same cycle is the only
      // overflow case; a coincident pop makes room for it.
      overflow = set_flag && is_full && !clr_flag;
      // Writes go ahead unless we are in drop-new overflow.
      wr_en    = set_flag && (!overflow || (OVERWRITE != 0));
      // The read pointer advances on a real pop, or when overwrite mode
      // replaces the oldest entry so dout moves on to the next-oldest.
      rd_adv   = (clr_flag && !is_empty) || (overflow && (OVERWRITE != 0));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Overwrite of a full queue sets both wr_en and rd_adv, so the
         // count holds at DEPTH, same as a simultaneous push and pop.
         case ({wr_en, rd_adv})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Set has priority over clear.
         if (overflow) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   assign flag = !is_empty;
   assign full = is_full;
   assign dout = mem[rd_ptr];

endmodule

// File: tb/tb_flag_fifo.sv
// tb/tb_flag_fifo.sv - randomized self-checking bench for flag_fifo, both full-policies side by side
module tb_flag_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       set_flag = 1'b0;
   logic [7:0] din = 8'h00;
   logic       clr_flag = 1'b0;
   logic       clr_overrun = 1'b0;

   logic       flag0, full0, overrun0;
   logic [7:0] dout0;
   logic [2:0] count0;
   logic       flag1, full1, overrun1;
   logic [7:0] dout1;
   logic [2:0] count1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mq [2][$];
   bit         mov [2];

   always #5 clk = ~clk;

   flag_fifo #(.DATA_W(8), .ADDR_W(2), .OVERWRITE(0)) dut0 (
      .clk(clk), .reset(reset), .set_flag(set_flag), .din(din),
      .clr_flag(clr_flag), .clr_overrun(clr_overrun),
      .flag(flag0), .dout(dout0), .full(full0), .count(count0), .overrun(overrun0)
   );

   flag_fifo #(.DATA_W(8), .ADDR_W(2), .OVERWRITE(1)) dut1 (
      .clk(clk), .reset(reset), .set_flag(set_flag), .din(din),
      .clr_flag(clr_flag), .clr_overrun(clr_overrun),
      .flag(flag1), .dout(dout1), .full(full1), .count(count1), .overrun(overrun1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         mq[p].delete();
         mov[p] = 1'b0;
      end
   endtask

   // Queue-level reference: p = 0 drops new data when full, p = 1 evicts the oldest.
   task automatic model_update(input bit s, input logic [7:0] d, input bit c, input bit co);
      for (int p = 0; p < 2; p++) begin
         int  n = mq[p].size();
         bit  ovf = 1'b0;
         if (s && c) begin
            if (n > 0) void'(mq[p].pop_front());
            mq[p].push_back(d);
         end else if (s) begin
            if (n < 4) begin
               mq[p].push_back(d);
            end else begin
               ovf = 1'b1;
               if (p == 1) begin
                  void'(mq[p].pop_front());
                  mq[p].push_back(d);
               end
            end
         end else if (c) begin
            if (n > 0) void'(mq[p].pop_front());
         end
         if (ovf) mov[p] = 1'b1;
         else if (co) mov[p] = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("d0 flag",    int'(flag0),    int'(mq[0].size() != 0));
      chk("d0 full",    int'(full0),    int'(mq[0].size() == 4));
      chk("d0 count",   int'(count0),   mq[0].size());
      chk("d0 overrun", int'(overrun0), int'(mov[0]));
      if (mq[0].size() != 0) chk("d0 dout", int'(dout0), int'(mq[0][0]));
      chk("d1 flag",    int'(flag1),    int'(mq[1].size() != 0));
      chk("d1 full",    int'(full1),    int'(mq[1].size() == 4));
      chk("d1 count",   int'(count1),   mq[1].size());
      chk("d1 overrun", int'(overrun1), int'(mov[1]));
      if (mq[1].size() != 0) chk("d1 dout", int'(dout1), int'(mq[1][0]));
   endtask

   task automatic check_reset_vals();
      chk("rst d0 flag",    int'(flag0),    0);
      chk("rst d0 full",    int'(full0),    0);
      chk("rst d0 count",   int'(count0),   0);
      chk("rst d0 overrun", int'(overrun0), 0);
      chk("rst d0 dout",    int'(dout0),    0);
      chk("rst d1 flag",    int'(flag1),    0);
      chk("rst d1 count",   int'(count1),   0);
      chk("rst d1 overrun", int'(overrun1), 0);
      chk("rst d1 dout",    int'(dout1),    0);
   endtask

   task automatic step(input bit s, input logic [7:0] d, input bit c, input bit co);
      @(negedge clk);
      set_flag = s; din = d; clr_flag = c; clr_overrun = co;
      @(posedge clk);
      model_update(s, d, c, co);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      set_flag = 1'b0; clr_flag = 1'b0; clr_overrun = 1'b0; din = 8'h00;
   endtask

   // Reset asserted between edges must take effect without a clock edge.
   task automatic async_reset();
      idle_inputs();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_reset_vals();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic push(input logic [7:0] d); step(1, d, 0, 0); endtask
   task automatic pop(); step(0, 8'h00, 1, 0); endtask

   initial begin
      model_reset();
      // 1. reset then idle
      repeat (2) @(posedge clk);
      #1 check_reset_vals();
      @(negedge clk) reset = 1'b1;
      step(0, 8'h00, 0, 0);

      // 2. single push/pop, pop while empty
      push(8'hE2);
      chk("t2 dout", int'(dout0), 8'hE2);
      pop();
      chk("t2 flag", int'(flag0), 0);
      pop();

      // 3. fill and wrap
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      chk("t3 full", int'(full0), 1);
      chk("t3 dout", int'(dout0), 8'h11);
      pop(); pop();
      push(8'h55); push(8'h66);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_seq [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
         chk("t3 seq", int'(dout0), int'(exp_seq[i]));
         pop();
      end

      // 4/5. overflow under both policies
      for (int i = 1; i <= 4; i++) push(8'(i));
      push(8'h05);
      chk("t4 ovr", int'(overrun0), 1);
      chk("t4 dout0", int'(dout0), 8'h01);
      chk("t5 dout1", int'(dout1), 8'h02);
      step(0, 8'h00, 0, 1);
      chk("t4 clr", int'(overrun0), 0);
      step(1, 8'h06, 0, 1);
      chk("t4 set wins", int'(overrun0), 1);
      for (int i = 0; i < 4; i++) pop();
      step(0, 8'h00, 0, 1);

      // 6. simultaneous strobes
      step(1, 8'h33, 1, 0);
      chk("t6 empty both", int'(count0), 1);
      pop();
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      step(1, 8'hA4, 1, 0);
      chk("t6 full dout", int'(dout0), 8'hA1);
      chk("t6 full ovr", int'(overrun1), 0);
      pop(); pop();
      step(1, 8'hB0, 1, 0);
      chk("t6 mid count", int'(count0), 2);

      // mid-run asynchronous reset
      push(8'h77);
      async_reset();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
         end else begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
         end
      end

      idle_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
